// File: rtl/msg_frame_uart_tx_if.sv
// Handshake/bus bundle between the message sequencer upstream and the framing UART transmitter.
interface msg_frame_uart_tx_if #(
  parameter int DATASIZE = 128
);
  logic                start;
  logic [DATASIZE-1:0] data;
  logic [5:0]          state;
  logic                ready;
  logic                tx_busy;
  logic                uart_txd;

  modport master (
    output start,
    output data,
    input  state,
    input  ready,
    input  tx_busy,
    input  uart_txd
  );

  modport slave (
    input  start,
    input  data,
    output state,
    output ready,
    output tx_busy,
    output uart_txd
  );
endinterface

// File: rtl/msg_frame_uart_tx.sv
// Message-framing 8N1 UART transmitter: sends a latched word MSB byte first.
// Optional macro SKIP_NULL_EN: zero bytes are skipped instead of transmitted.
module msg_frame_uart_tx #(
  parameter int DATASIZE     = 128,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_RATE     = 9_600
) (
  input  logic              clk,
  input  logic              resetn,
  msg_frame_uart_tx_if.slave bus
);

  localparam int NBYTES = DATASIZE / PAYLOAD_BITS;
  localparam int CYC    = CLK_HZ / BIT_RATE;
  localparam int CW     = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int BW     = $clog2(PAYLOAD_BITS + 2);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CYC - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS + 1);
  localparam logic [5:0]    LAST_IDX  = 6'(NBYTES - 1);
  localparam logic [5:0]    CODE_DONE = 6'(NBYTES);
  localparam logic [5:0]    CODE_IDLE = 6'(NBYTES + 1);
  localparam logic [5:0]    CODE_LOAD = 6'(NBYTES + 2);

  typedef enum logic [1:0] {S_SEND, S_DONE, S_IDLE, S_LOAD} phase_t;

  phase_t                  r_phase, w_phaseNext;
  logic [5:0]              r_idx, w_idxNext;
  logic                    r_issued, w_issuedNext;
  logic [DATASIZE-1:0]     r_msg, w_msgNext;
  logic                    w_txEn;
  logic                    w_advance;
  logic [PAYLOAD_BITS-1:0] w_curByte;
  logic [5:0]              w_stateCode;

  logic                    r_txBusy;
  logic                    r_txd;
  logic [PAYLOAD_BITS:0]   r_frame;
  logic [CW-1:0]           r_cycCnt;
  logic [BW-1:0]           r_bitCnt;

  // The message register shifts left as bytes complete, so the current byte is always on top.
  assign w_curByte = r_msg[DATASIZE-1 -: PAYLOAD_BITS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase  <= S_IDLE;
      r_idx    <= '0;
      r_issued <= 1'b0;
      r_msg    <= '0;
    end else begin
      r_phase  <= w_phaseNext;
      r_idx    <= w_idxNext;
      r_issued <= w_issuedNext;
      r_msg    <= w_msgNext;
    end
  end

  always_comb begin
    w_phaseNext  = r_phase;
    w_idxNext    = r_idx;
    w_issuedNext = r_issued;
    w_msgNext    = r_msg;
    w_txEn       = 1'b0;
    w_advance    = 1'b0;
    case (r_phase)
      S_IDLE, S_LOAD: begin
        if (bus.start) begin
          w_msgNext    = bus.data;
          w_idxNext    = '0;
          w_issuedNext = 1'b0;
          w_phaseNext  = S_SEND;
        end else if (r_phase == S_LOAD) begin
          w_phaseNext = S_IDLE;
        end
      end
      S_SEND: begin
        if (!r_issued) begin
`ifdef SKIP_NULL_EN
          if (w_curByte == '0) begin
            w_advance = 1'b1;
          end else if (!r_txBusy) begin
            w_txEn       = 1'b1;
            w_issuedNext = 1'b1;
          end
`else
          if (!r_txBusy) begin
            w_txEn       = 1'b1;
            w_issuedNext = 1'b1;
          end
`endif
        end else if (!r_txBusy) begin
          w_advance = 1'b1;
        end
        if (w_advance) begin
          w_issuedNext = 1'b0;
          w_msgNext    = r_msg << PAYLOAD_BITS;
          if (r_idx == LAST_IDX) begin
            w_phaseNext = S_DONE;
          end else begin
            w_idxNext = r_idx + 6'd1;
          end
        end
      end
      S_DONE: w_phaseNext = S_LOAD;
      default: w_phaseNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_stateCode = CODE_IDLE;
    case (r_phase)
      S_SEND:  w_stateCode = r_idx;
      S_DONE:  w_stateCode = CODE_DONE;
      S_LOAD:  w_stateCode = CODE_LOAD;
      default: w_stateCode = CODE_IDLE;
    endcase
  end

  // Bit engine: the start bit is driven on load; the frame register holds data bits then the stop bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_txBusy <= 1'b0;
      r_txd    <= 1'b1;
      r_frame  <= '0;
      r_cycCnt <= '0;
      r_bitCnt <= '0;
    end else if (!r_txBusy) begin
      if (w_txEn) begin
        r_frame  <= {1'b1, w_curByte};
        r_txBusy <= 1'b1;
        r_txd    <= 1'b0;
        r_cycCnt <= '0;
        r_bitCnt <= '0;
      end
    end else if (r_cycCnt == CYC_LAST) begin
      r_cycCnt <= '0;
      if (r_bitCnt == BIT_LAST) begin
        r_txBusy <= 1'b0;
        r_txd    <= 1'b1;
      end else begin
        r_bitCnt <= r_bitCnt + 1'b1;
        r_txd    <= r_frame[0];
        r_frame  <= r_frame >> 1;
      end
    end else begin
      r_cycCnt <= r_cycCnt + 1'b1;
    end
  end

  assign bus.state    = w_stateCode;
  assign bus.ready    = (r_phase == S_DONE) & ~r_txBusy;
  assign bus.tx_busy  = r_txBusy;
  assign bus.uart_txd = r_txd;

endmodule

// File: tb/tb_msg_frame_uart_tx.sv
// Self-checking bench: a per-cycle waveform model expanded from each accepted message,
// a mid-bit UART decoder, and directed literal checks that pin the model.
module tb_msg_frame_uart_tx;

  localparam int DATASIZE = 32;
  localparam int PB       = 8;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int CYC      = CLK_HZ / BIT_RATE;
  localparam int NBYTES   = DATASIZE / PB;
  localparam int MSG_MAX  = NBYTES * (10 * CYC + 2) + 10;
`ifdef SKIP_NULL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] st;
    logic       rdy;
    logic       bsy;
    logic       txd;
    logic       isLoad;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  msg_frame_uart_tx_if #(.DATASIZE(DATASIZE)) bus ();

  msg_frame_uart_tx #(
    .DATASIZE(DATASIZE), .PAYLOAD_BITS(PB), .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int assertCount = 0;
  int failCount   = 0;
  int readyCount  = 0;

  exp_t       expQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] expBytes[$];
  logic [9:0] fbQ[$];

  // Expand one accepted message into the exact waveform every output must follow.
  function automatic void buildSchedule(input logic [DATASIZE-1:0] w);
    logic [PB-1:0] b;
    logic [PB+1:0] fr;
    for (int k = 0; k < NBYTES; k++) begin
      b = w[DATASIZE-1-k*PB -: PB];
      if (SKIP && b == '0) begin
        expQ.push_back('{6'(k), 1'b0, 1'b0, 1'b1, 1'b0});
      end else begin
        expQ.push_back('{6'(k), 1'b0, 1'b0, 1'b1, 1'b0});
        fr = {1'b1, b, 1'b0};
        for (int j = 0; j < PB + 2; j++)
          for (int c = 0; c < CYC; c++)
            expQ.push_back('{6'(k), 1'b0, 1'b1, fr[j], 1'b0});
        expQ.push_back('{6'(k), 1'b0, 1'b0, 1'b1, 1'b0});
      end
    end
    expQ.push_back('{6'(NBYTES), 1'b1, 1'b0, 1'b1, 1'b0});
    expQ.push_back('{6'(NBYTES + 2), 1'b0, 1'b0, 1'b1, 1'b1});
  endfunction

  function automatic void addExpected(input logic [DATASIZE-1:0] w);
    logic [7:0] b;
    for (int k = 0; k < NBYTES; k++) begin
      b = w[DATASIZE-1-k*PB -: PB];
      if (!(SKIP && b == 8'h00)) expBytes.push_back(b);
    end
  endfunction

  // Compare process: one check per cycle of all four outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    bit   accepting;
    if (!resetn) begin
      expQ.delete();
    end else begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        accepting = e.isLoad;
      end else begin
        e = '{6'(NBYTES + 1), 1'b0, 1'b0, 1'b1, 1'b0};
        accepting = 1'b1;
      end
      assertCount++;
      if ({bus.state, bus.ready, bus.tx_busy, bus.uart_txd} !== {e.st, e.rdy, e.bsy, e.txd}) begin
        failCount++;
        $display("[TB] FAIL cycle@%0t state/ready/busy/txd got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 $time, bus.state, bus.ready, bus.tx_busy, bus.uart_txd, e.st, e.rdy, e.bsy, e.txd);
      end
      if (bus.ready === 1'b1) readyCount++;
      if (accepting && bus.start === 1'b1) buildSchedule(bus.data);
    end
  end

  // Mid-bit UART decoder of the serial line.
  bit         rxActive = 1'b0;
  int         rxCnt    = 0;
  logic [9:0] rxBits;
  always @(negedge clk) begin
    if (!resetn) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (bus.uart_txd === 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 1;
      end
    end else begin
      if (rxCnt % CYC == CYC / 2) begin
        rxBits[rxCnt / CYC] = bus.uart_txd;
        if (rxCnt / CYC == 9) begin
          rxActive = 1'b0;
          rxQ.push_back(rxBits[8:1]);
          fbQ.push_back(rxBits);
        end
      end
      rxCnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, " byte count"}, 32'(rxQ.size()), 32'(expBytes.size()));
    for (int i = 0; i < rxQ.size() && i < expBytes.size(); i++)
      checkOutput($sformatf("%s byte %0d", name, i), 32'(rxQ[i]), 32'(expBytes[i]));
    rxQ.delete();
    expBytes.delete();
    fbQ.delete();
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (bus.ready !== 1'b1 && n < MSG_MAX) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      failCount++;
      assertCount++;
      $display("[TB] FAIL %s ready timeout got 0 want 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DATASIZE-1:0] w, input int hold);
    @(posedge clk);
    #1;
    bus.data  = w;
    bus.start = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [DATASIZE-1:0] randWord(input bit allowZero);
    logic [DATASIZE-1:0] w;
    for (int k = 0; k < NBYTES; k++)
      w[k*PB +: PB] = (allowZero && $urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return w;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int rc;
    logic [DATASIZE-1:0] w;
    logic [DATASIZE-1:0] words[3];

    bus.start = 1'b0;
    bus.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", 32'(bus.state), 32'(NBYTES + 1));
    checkOutput("reset txd", 32'(bus.uart_txd), 32'd1);
    checkOutput("reset busy", 32'(bus.tx_busy), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] single frame line pattern");
    rc = readyCount;
    applyStimulus(32'hA53C817E, 1);
    waitReady("pattern");
    repeat (3) @(posedge clk);
    checkOutput("A5 line bits", 32'(fbQ.size() > 0 ? fbQ[0] : 10'h0), 32'(10'b1101001010));
    checkOutput("pattern ready pulses", 32'(readyCount - rc), 32'd1);
    checkOutput("pattern back to idle", 32'(bus.state), 32'(NBYTES + 1));
    expBytes = '{8'hA5, 8'h3C, 8'h81, 8'h7E};
    checkRx("pattern");

    $display("[TB] byte order");
    rc = readyCount;
    applyStimulus(32'h0A0D4341, 1);
    waitReady("order");
    repeat (3) @(posedge clk);
    checkOutput("order ready pulses", 32'(readyCount - rc), 32'd1);
    expBytes = '{8'h0A, 8'h0D, 8'h43, 8'h41};
    checkRx("order");

    $display("[TB] null bytes");
    applyStimulus(32'h00000A43, 1);
    waitReady("null");
    repeat (3) @(posedge clk);
    if (SKIP) expBytes = '{8'h0A, 8'h43};
    else      expBytes = '{8'h00, 8'h00, 8'h0A, 8'h43};
    checkRx("null");

    rc = readyCount;
    applyStimulus(32'h00000000, 1);
    waitReady("allzero");
    repeat (3) @(posedge clk);
    checkOutput("allzero ready pulses", 32'(readyCount - rc), 32'd1);
    if (SKIP) expBytes = {};
    else      expBytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    checkRx("allzero");

    $display("[TB] chaining");
    rc = readyCount;
    for (int m = 0; m < 3; m++) begin
      words[m] = randWord(1'b1);
      addExpected(words[m]);
    end
    @(posedge clk);
    #1;
    bus.data  = words[0];
    bus.start = 1'b1;
    for (int m = 0; m < 3; m++) begin
      waitReady("chain");
      if (m < 2) bus.data = words[m+1];
      else       bus.start = 1'b0;
    end
    repeat (3) @(posedge clk);
    checkOutput("chain ready pulses", 32'(readyCount - rc), 32'd3);
    checkRx("chain");

    $display("[TB] data change during send");
    w = randWord(1'b0);
    addExpected(w);
    applyStimulus(w, 1);
    repeat (120) @(posedge clk);
    #1;
    bus.data = ~w;
    waitReady("midchange");
    repeat (3) @(posedge clk);
    checkRx("midchange");

    $display("[TB] randomized messages");
    for (int r = 0; r < 10; r++) begin
      w = randWord(1'b1);
      addExpected(w);
      applyStimulus(w, int'($urandom_range(1, 3)));
      waitReady("random");
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
    end
    checkRx("random");

    $display("[TB] reset mid-frame");
    applyStimulus(32'hFFEEDDCC, 1);
    repeat (150) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("abort txd", 32'(bus.uart_txd), 32'd1);
    checkOutput("abort busy", 32'(bus.tx_busy), 32'd0);
    checkOutput("abort state", 32'(bus.state), 32'(NBYTES + 1));
    checkOutput("abort ready", 32'(bus.ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    rxQ.delete();
    fbQ.delete();
    repeat (5) @(posedge clk);
    w = randWord(1'b1);
    addExpected(w);
    applyStimulus(w, 1);
    waitReady("after reset");
    repeat (3) @(posedge clk);
    checkRx("after reset");

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
